// File: rtl/vending_pkg.sv
// Shared types, event codes and the coin summing helper for the vending core.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        CHANGE,
        ADMIN
    } state_t;

    localparam logic [2:0] EV_NONE     = 3'd0;
    localparam logic [2:0] EV_COIN     = 3'd1;
    localparam logic [2:0] EV_VEND     = 3'd2;
    localparam logic [2:0] EV_NO_MONEY = 3'd3;
    localparam logic [2:0] EV_SOLD_OUT = 3'd4;
    localparam logic [2:0] EV_REJECT   = 3'd5;
    localparam logic [2:0] EV_CHANGE   = 3'd6;
    localparam logic [2:0] EV_ADMIN    = 3'd7;

    // Sums the values of all asserted coin pulses; values are packed w bits per coin.
    function automatic logic [31:0] coin_sum(input logic [31:0]  pulse,
                                             input logic [511:0] values,
                                             input int unsigned  n,
                                             input int unsigned  w);
        logic [31:0] acc;
        logic [31:0] mask;
        acc  = '0;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        for (int unsigned i = 0; i < n; i++) begin
            if (pulse[i]) acc = acc + (32'(values >> (i * w)) & mask);
        end
        return acc;
    endfunction

endpackage

// File: rtl/vending_item_store.sv
// Per-item price/stock register file: two read ports, a stock decrement port
// and saturating admin edit ports.
module vending_item_store
    import vending_pkg::*;
#(
    parameter int unsigned N_ITEMS    = 8,
    parameter int unsigned MONEY_W    = 8,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned INIT_PRICE = 5,
    parameter int unsigned INIT_STOCK = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(N_ITEMS)-1:0] rd_idx,
    output logic [MONEY_W-1:0]         rd_price,
    output logic [STOCK_W-1:0]         rd_stock,
    input  logic [$clog2(N_ITEMS)-1:0] chk_idx,
    output logic [MONEY_W-1:0]         chk_price,
    output logic [STOCK_W-1:0]         chk_stock,
    input  logic                       dec_en,
    input  logic [$clog2(N_ITEMS)-1:0] dec_idx,
    input  logic                       edit_en,
    input  logic [$clog2(N_ITEMS)-1:0] edit_idx,
    input  logic                       price_up,
    input  logic                       price_dn,
    input  logic                       stock_up
);

    logic [MONEY_W-1:0] price [N_ITEMS];
    logic [STOCK_W-1:0] stock [N_ITEMS];

    assign rd_price  = price[rd_idx];
    assign rd_stock  = stock[rd_idx];
    assign chk_price = price[chk_idx];
    assign chk_stock = stock[chk_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_ITEMS; i++) begin
                price[i] <= MONEY_W'(INIT_PRICE);
                stock[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            if (dec_en && stock[dec_idx] != '0) begin
                stock[dec_idx] <= stock[dec_idx] - STOCK_W'(1);
            end
            if (edit_en) begin
                // Price never drops below 1 so an item can not become free.
                if (price_up && price[edit_idx] != '1) begin
                    price[edit_idx] <= price[edit_idx] + MONEY_W'(1);
                end else if (price_dn && price[edit_idx] > MONEY_W'(1)) begin
                    price[edit_idx] <= price[edit_idx] - MONEY_W'(1);
                end
                if (stock_up && stock[edit_idx] != '1) begin
                    stock[edit_idx] <= stock[edit_idx] + STOCK_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/vending_core_param.sv
// Parametrised vending controller: credit keeping, item vend and change
// handshakes, admin price/stock editing and an inactivity auto-refund.
module vending_core_param
    import vending_pkg::*;
#(
    parameter int unsigned                 N_ITEMS     = 8,
    parameter int unsigned                 N_COINS     = 3,
    parameter int unsigned                 MONEY_W     = 8,
    parameter int unsigned                 STOCK_W     = 4,
    parameter logic [N_COINS*MONEY_W-1:0]  COIN_VALUES = {8'd10, 8'd5, 8'd1},
    parameter int unsigned                 INIT_PRICE  = 5,
    parameter int unsigned                 INIT_STOCK  = 3,
    parameter int unsigned                 TIMEOUT_CYC = 1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_COINS-1:0]         coin_pulse,
    input  logic [N_ITEMS-1:0]         item_sel,
    input  logic                       refund_req,
    input  logic                       admin_mode,
    input  logic                       admin_price_up,
    input  logic                       admin_price_dn,
    input  logic                       admin_stock_up,
    output logic                       dispense_valid,
    output logic [$clog2(N_ITEMS)-1:0] dispense_item,
    input  logic                       dispense_ready,
    output logic                       change_valid,
    output logic [MONEY_W-1:0]         change_amount,
    input  logic                       change_ready,
    output logic [MONEY_W-1:0]         credit,
    output logic [$clog2(N_ITEMS)-1:0] sel_idx,
    output logic [MONEY_W-1:0]         sel_price,
    output logic [STOCK_W-1:0]         sel_stock,
    output logic [2:0]                 event_code,
    output logic                       event_pulse
);

    localparam int unsigned IDX_W = $clog2(N_ITEMS);
    localparam int unsigned SUM_W = MONEY_W + $clog2(N_COINS) + 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t             state;
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   total;
    logic               coin_any;
    logic               coin_ok;
    logic [MONEY_W-1:0] coin_credit;
    logic               sel_any;
    logic [IDX_W-1:0]   pick;
    logic [MONEY_W-1:0] chk_price;
    logic [STOCK_W-1:0] chk_stock;
    logic               vend_ok;
    logic               pulse_any;
    logic               timeout;
    logic [CNT_W-1:0]   idle_cnt;

    always_comb begin
        sum         = SUM_W'(coin_sum(32'(coin_pulse), 512'(COIN_VALUES), N_COINS, MONEY_W));
        total       = SUM_W'(credit) + sum;
        coin_any    = |coin_pulse;
        coin_ok     = total <= SUM_W'({MONEY_W{1'b1}});
        coin_credit = coin_ok ? total[MONEY_W-1:0] : credit;
        sel_any     = |item_sel;
        pick        = '0;
        // Scan downward so the lowest asserted button is the last written.
        for (int unsigned i = N_ITEMS; i > 0; i--) begin
            if (item_sel[i-1]) pick = IDX_W'(i - 1);
        end
        vend_ok   = sel_any && chk_stock != '0 && chk_price <= credit;
        pulse_any = coin_any | sel_any | refund_req |
                    admin_price_up | admin_price_dn | admin_stock_up;
        timeout   = idle_cnt == CNT_W'(TIMEOUT_CYC - 1) && !pulse_any && credit != '0;
    end

    vending_item_store #(
        .N_ITEMS    (N_ITEMS),
        .MONEY_W    (MONEY_W),
        .STOCK_W    (STOCK_W),
        .INIT_PRICE (INIT_PRICE),
        .INIT_STOCK (INIT_STOCK)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (sel_idx),
        .rd_price  (sel_price),
        .rd_stock  (sel_stock),
        .chk_idx   (pick),
        .chk_price (chk_price),
        .chk_stock (chk_stock),
        .dec_en    (state == IDLE && !admin_mode && vend_ok),
        .dec_idx   (pick),
        .edit_en   (state == ADMIN && admin_mode),
        .edit_idx  (sel_idx),
        .price_up  (admin_price_up),
        .price_dn  (admin_price_dn),
        .stock_up  (admin_stock_up)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            credit         <= '0;
            sel_idx        <= '0;
            dispense_valid <= 1'b0;
            dispense_item  <= '0;
            change_valid   <= 1'b0;
            change_amount  <= '0;
            event_code     <= EV_NONE;
            event_pulse    <= 1'b0;
            idle_cnt       <= '0;
        end else begin
            event_pulse <= 1'b0;
            event_code  <= EV_NONE;
            case (state)
                IDLE: begin
                    idle_cnt <= (pulse_any || credit == '0 || admin_mode || timeout)
                                ? '0 : idle_cnt + CNT_W'(1);
                    if (admin_mode) begin
                        state       <= ADMIN;
                        event_pulse <= 1'b1;
                        event_code  <= EV_ADMIN;
                    end else begin
                        if (coin_any) begin
                            credit      <= coin_credit;
                            event_pulse <= 1'b1;
                            event_code  <= coin_ok ? EV_COIN : EV_REJECT;
                        end
                        // Later assignments override the coin event; its credit still lands.
                        if (sel_any) begin
                            sel_idx     <= pick;
                            event_pulse <= 1'b1;
                            if (chk_stock == '0) begin
                                event_code <= EV_SOLD_OUT;
                            end else if (chk_price > credit) begin
                                event_code <= EV_NO_MONEY;
                            end else begin
                                credit         <= coin_credit - chk_price;
                                dispense_valid <= 1'b1;
                                dispense_item  <= pick;
                                state          <= DISPENSE;
                                event_code     <= EV_VEND;
                            end
                        end else if ((refund_req && credit != '0) || timeout) begin
                            change_amount <= credit;
                            change_valid  <= 1'b1;
                            credit        <= coin_credit - credit;
                            state         <= CHANGE;
                        end
                    end
                end
                DISPENSE: begin
                    idle_cnt <= '0;
                    if (coin_any) begin
                        credit      <= coin_credit;
                        event_pulse <= 1'b1;
                        event_code  <= coin_ok ? EV_COIN : EV_REJECT;
                    end
                    if (dispense_ready) begin
                        dispense_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                CHANGE: begin
                    idle_cnt <= '0;
                    if (coin_any) begin
                        event_pulse <= 1'b1;
                        event_code  <= EV_REJECT;
                    end
                    if (change_ready) begin
                        change_valid  <= 1'b0;
                        change_amount <= '0;
                        state         <= IDLE;
                        event_pulse   <= 1'b1;
                        event_code    <= EV_CHANGE;
                    end
                end
                ADMIN: begin
                    idle_cnt <= '0;
                    if (coin_any) begin
                        event_pulse <= 1'b1;
                        event_code  <= EV_REJECT;
                    end
                    if (!admin_mode) begin
                        state <= IDLE;
                    end else if (sel_any) begin
                        sel_idx <= pick;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_core_param.sv
// Self-checking bench: directed vector table, corner-case sequences and
// randomized traffic against a behavioural model of the vending rules.
module tb_vending_core_param;

    localparam int TMO = 16;
    localparam int S_IDLE = 0, S_DISP = 1, S_CHG = 2, S_ADM = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] coin_pulse = '0;
    logic [7:0] item_sel = '0;
    logic       refund_req = 1'b0;
    logic       admin_mode = 1'b0;
    logic       admin_price_up = 1'b0, admin_price_dn = 1'b0, admin_stock_up = 1'b0;
    logic       dispense_ready = 1'b0, change_ready = 1'b0;
    logic       dispense_valid, change_valid, event_pulse;
    logic [2:0] dispense_item, sel_idx, event_code;
    logic [7:0] change_amount, credit, sel_price;
    logic [3:0] sel_stock;

    always #5 clk = ~clk;

    vending_core_param #(
        .N_ITEMS     (8),
        .N_COINS     (3),
        .MONEY_W     (8),
        .STOCK_W     (4),
        .COIN_VALUES ({8'd1, 8'd5, 8'd10}),
        .INIT_PRICE  (5),
        .INIT_STOCK  (3),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .coin_pulse     (coin_pulse),
        .item_sel       (item_sel),
        .refund_req     (refund_req),
        .admin_mode     (admin_mode),
        .admin_price_up (admin_price_up),
        .admin_price_dn (admin_price_dn),
        .admin_stock_up (admin_stock_up),
        .dispense_valid (dispense_valid),
        .dispense_item  (dispense_item),
        .dispense_ready (dispense_ready),
        .change_valid   (change_valid),
        .change_amount  (change_amount),
        .change_ready   (change_ready),
        .credit         (credit),
        .sel_idx        (sel_idx),
        .sel_price      (sel_price),
        .sel_stock      (sel_stock),
        .event_code     (event_code),
        .event_pulse    (event_pulse)
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    int cval [3] = '{10, 5, 1};
    int m_state, m_credit, m_sel, m_dv, m_di, m_cv, m_ca, m_ev, m_ep, m_cnt;
    int m_price [8];
    int m_stock [8];

    typedef struct {
        logic [2:0] coin;
        logic [7:0] item;
        logic       refund, dr, cr;
        int         credit, ev, dv, di, cv, ca, stock;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_credit = 0; m_sel = 0; m_dv = 0; m_di = 0;
        m_cv = 0; m_ca = 0; m_ev = 0; m_ep = 0; m_cnt = 0;
        for (int i = 0; i < 8; i++) begin m_price[i] = 5; m_stock[i] = 3; end
    endtask

    // Applies the vending rules to the inputs present before the next edge.
    task automatic model_step();
        int  sum, oc, k;
        bit  pulses, tmo, coins;
        sum = 0;
        for (int i = 0; i < 3; i++) if (coin_pulse[i]) sum += cval[i];
        coins  = |coin_pulse;
        oc     = m_credit;
        k      = lowest(item_sel);
        pulses = coins || k >= 0 || refund_req || admin_price_up || admin_price_dn || admin_stock_up;
        m_ev   = 0;
        case (m_state)
            S_IDLE: begin
                tmo   = (m_cnt == TMO - 1) && !pulses && oc != 0;
                m_cnt = (pulses || oc == 0 || admin_mode || tmo) ? 0 : m_cnt + 1;
                if (admin_mode) begin
                    m_state = S_ADM; m_ev = 7;
                end else begin
                    if (coins) begin
                        if (oc + sum <= 255) begin m_credit = oc + sum; m_ev = 1; end
                        else m_ev = 5;
                    end
                    if (k >= 0) begin
                        m_sel = k;
                        if (m_stock[k] == 0) m_ev = 4;
                        else if (m_price[k] > oc) m_ev = 3;
                        else begin
                            m_credit -= m_price[k]; m_stock[k]--;
                            m_dv = 1; m_di = k; m_state = S_DISP; m_ev = 2;
                        end
                    end else if ((refund_req && oc > 0) || tmo) begin
                        m_ca = oc; m_cv = 1; m_credit -= oc; m_state = S_CHG;
                    end
                end
            end
            S_DISP: begin
                m_cnt = 0;
                if (coins) begin
                    if (oc + sum <= 255) begin m_credit = oc + sum; m_ev = 1; end
                    else m_ev = 5;
                end
                if (dispense_ready) begin m_dv = 0; m_state = S_IDLE; end
            end
            S_CHG: begin
                m_cnt = 0;
                if (coins) m_ev = 5;
                if (change_ready) begin m_cv = 0; m_ca = 0; m_state = S_IDLE; m_ev = 6; end
            end
            default: begin
                m_cnt = 0;
                if (coins) m_ev = 5;
                if (!admin_mode) m_state = S_IDLE;
                else begin
                    if (admin_price_up && m_price[m_sel] < 255) m_price[m_sel]++;
                    else if (admin_price_dn && m_price[m_sel] > 1) m_price[m_sel]--;
                    if (admin_stock_up && m_stock[m_sel] < 15) m_stock[m_sel]++;
                    if (k >= 0) m_sel = k;
                end
            end
        endcase
        m_ep = (m_ev != 0) ? 1 : 0;
    endtask

    function automatic logic [63:0] dut_bus();
        return 64'({credit, sel_idx, sel_price, sel_stock, event_code, event_pulse,
                    dispense_valid, dispense_item, change_valid, change_amount});
    endfunction

    function automatic logic [63:0] model_bus();
        return 64'({8'(m_credit), 3'(m_sel), 8'(m_price[m_sel]), 4'(m_stock[m_sel]),
                    3'(m_ev), 1'(m_ep), 1'(m_dv), 3'(m_di), 1'(m_cv), 8'(m_ca)});
    endfunction

    task automatic step(input string name);
        model_step();
        @(posedge clk);
        #1;
        chk(name, dut_bus(), model_bus());
        coin_pulse = '0; item_sel = '0; refund_req = 1'b0;
        admin_price_up = 1'b0; admin_price_dn = 1'b0; admin_stock_up = 1'b0;
    endtask

    task automatic add(input logic [2:0] c, input logic [7:0] it, input logic rf,
                       input logic d, input logic r, input int cr_, input int ev,
                       input int dv, input int di, input int cv, input int ca, input int st);
        vec_t v;
        v = '{c, it, rf, d, r, cr_, ev, dv, di, cv, ca, st};
        vq.push_back(v);
    endtask

    // Credit builds from 7 (or 8 after a restart coin) and must refund exactly TMO idle cycles later.
    task automatic timeout_run(input int restart_at);
        int rise, amt;
        rise = (restart_at > 0) ? restart_at + TMO : TMO;
        amt  = (restart_at > 0) ? 8 : 7;
        coin_pulse = 3'b110; step("to_coin_a");
        coin_pulse = 3'b100; step("to_coin_b");
        chk("to_credit7", 64'(credit), 64'd7);
        for (int k = 1; k <= rise; k++) begin
            if (k == restart_at) coin_pulse = 3'b100;
            step("to_idle");
            chk("to_change_valid", 64'(change_valid), (k == rise) ? 64'd1 : 64'd0);
        end
        chk("to_amount", 64'(change_amount), 64'(amt));
        change_ready = 1'b1; step("to_ack");
        change_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset", 64'({credit, sel_idx, dispense_valid, change_valid, change_amount,
                          event_code, event_pulse, sel_price, sel_stock}),
            64'({8'd0, 3'd0, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 8'd5, 4'd3}));

        //   coin    item   rf    dr    cr    credit ev dv di cv ca stock
        add(3'b001, 8'h00, 1'b0, 1'b0, 1'b0, 10, 1, 0, 0, 0, 0, 3);
        add(3'b000, 8'h04, 1'b0, 1'b0, 1'b0,  5, 2, 1, 2, 0, 0, 2);
        add(3'b000, 8'h00, 1'b0, 1'b0, 1'b0,  5, 0, 1, 2, 0, 0, 2);
        add(3'b000, 8'h00, 1'b0, 1'b0, 1'b0,  5, 0, 1, 2, 0, 0, 2);
        add(3'b000, 8'h00, 1'b0, 1'b0, 1'b0,  5, 0, 1, 2, 0, 0, 2);
        add(3'b000, 8'h00, 1'b0, 1'b1, 1'b0,  5, 0, 0, 2, 0, 0, 2);
        add(3'b000, 8'h00, 1'b1, 1'b0, 1'b0,  0, 0, 0, 2, 1, 5, 2);
        add(3'b000, 8'h00, 1'b0, 1'b0, 1'b1,  0, 6, 0, 2, 0, 0, 2);
        add(3'b100, 8'h00, 1'b0, 1'b0, 1'b0,  1, 1, 0, 2, 0, 0, 2);
        add(3'b100, 8'h00, 1'b0, 1'b0, 1'b0,  2, 1, 0, 2, 0, 0, 2);
        add(3'b100, 8'h00, 1'b0, 1'b0, 1'b0,  3, 1, 0, 2, 0, 0, 2);
        add(3'b000, 8'h01, 1'b0, 1'b0, 1'b0,  3, 3, 0, 2, 0, 0, 3);
        add(3'b000, 8'h00, 1'b1, 1'b0, 1'b0,  0, 0, 0, 2, 1, 3, 3);
        add(3'b000, 8'h00, 1'b0, 1'b0, 1'b0,  0, 0, 0, 2, 1, 3, 3);
        add(3'b000, 8'h00, 1'b0, 1'b0, 1'b1,  0, 6, 0, 2, 0, 0, 3);
        add(3'b001, 8'h00, 1'b0, 1'b0, 1'b0, 10, 1, 0, 2, 0, 0, 3);
        add(3'b001, 8'h00, 1'b0, 1'b0, 1'b0, 20, 1, 0, 2, 0, 0, 3);
        add(3'b000, 8'h10, 1'b0, 1'b0, 1'b0, 15, 2, 1, 4, 0, 0, 2);
        add(3'b000, 8'h00, 1'b0, 1'b1, 1'b0, 15, 0, 0, 4, 0, 0, 2);
        add(3'b000, 8'h10, 1'b0, 1'b0, 1'b0, 10, 2, 1, 4, 0, 0, 1);
        add(3'b000, 8'h00, 1'b0, 1'b1, 1'b0, 10, 0, 0, 4, 0, 0, 1);
        add(3'b000, 8'h10, 1'b0, 1'b0, 1'b0,  5, 2, 1, 4, 0, 0, 0);
        add(3'b000, 8'h00, 1'b0, 1'b1, 1'b0,  5, 0, 0, 4, 0, 0, 0);
        add(3'b000, 8'h10, 1'b0, 1'b0, 1'b0,  5, 4, 0, 4, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            coin_pulse = vq[i].coin; item_sel = vq[i].item; refund_req = vq[i].refund;
            dispense_ready = vq[i].dr; change_ready = vq[i].cr;
            step("table_model");
            chk($sformatf("table_%0d", i),
                64'({credit, event_code, dispense_valid, dispense_item, change_valid,
                     change_amount, sel_stock}),
                64'({8'(vq[i].credit), 3'(vq[i].ev), 1'(vq[i].dv), 3'(vq[i].di),
                     1'(vq[i].cv), 8'(vq[i].ca), 4'(vq[i].stock)}));
        end
        dispense_ready = 1'b0; change_ready = 1'b0;

        // Overflow guard at 250 and a two-coin insert from zero
        for (int i = 0; i < 24; i++) begin coin_pulse = 3'b001; step("fill"); end
        coin_pulse = 3'b010; step("fill");
        chk("credit250", 64'(credit), 64'd250);
        coin_pulse = 3'b001; step("overflow");
        chk("reject", 64'({credit, event_code, event_pulse}), 64'({8'd250, 3'd5, 1'b1}));
        refund_req = 1'b1; step("refund250");
        chk("refund250_amt", 64'({change_valid, change_amount}), 64'({1'b1, 8'd250}));
        change_ready = 1'b1; step("refund250_ack");
        change_ready = 1'b0;
        coin_pulse = 3'b011; step("dual_coin");
        chk("dual_coin", 64'({credit, event_code, event_pulse}), 64'({8'd15, 3'd1, 1'b1}));

        // Admin edits with saturation, credit survives the visit
        admin_mode = 1'b1; step("adm_enter");
        chk("adm_event", 64'(event_code), 64'd7);
        item_sel = 8'h80; step("adm_sel");
        chk("adm_sel_idx", 64'(sel_idx), 64'd7);
        for (int i = 0; i < 6; i++) begin admin_price_dn = 1'b1; step("adm_dn"); end
        chk("price_floor", 64'(sel_price), 64'd1);
        for (int i = 0; i < 20; i++) begin admin_stock_up = 1'b1; step("adm_su"); end
        chk("stock_sat", 64'(sel_stock), 64'd15);
        admin_mode = 1'b0; step("adm_exit");
        chk("adm_credit", 64'(credit), 64'd15);
        refund_req = 1'b1; step("clr_refund");
        change_ready = 1'b1; step("clr_ack");
        change_ready = 1'b0;

        timeout_run(0);
        timeout_run(10);

        // Reset in the middle of a dispense handshake
        coin_pulse = 3'b001; step("rm_coin");
        item_sel = 8'h08; step("rm_vend");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("reset_mid", 64'({dispense_valid, credit, change_valid, sel_idx, sel_price, sel_stock}),
            64'({1'b0, 8'd0, 1'b0, 3'd0, 8'd5, 4'd3}));

        for (int n = 0; n < 3000; n++) begin
            int r;
            coin_pulse = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            r = $urandom_range(0, 9);
            item_sel = (r == 0) ? 8'(1 << $urandom_range(0, 7)) : (r == 1) ? 8'($urandom) : 8'h00;
            refund_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 59) == 0) admin_mode = ~admin_mode;
            admin_price_up = ($urandom_range(0, 9) == 0);
            admin_price_dn = ($urandom_range(0, 9) == 0);
            admin_stock_up = ($urandom_range(0, 5) == 0);
            dispense_ready = 1'($urandom_range(0, 1));
            change_ready   = 1'($urandom_range(0, 1));
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vending_core_param.md
Name: vending_core_param

Overview:
- Parametrised successor to the fixed-menu vending controller. Supports N_ITEMS items with per-item price and stock registers, N_COINS coin denominations, an admin edit mode, a dispense handshake, a change handshake, and an inactivity auto-refund.
- Sits between the one-shot button layer and the display, piezo and LCD drivers.
- Emits the credit for the FND array and a 3-bit event code for the piezo.

Parameters:
- N_ITEMS, 8, number of selectable items.
- N_COINS, 3, number of coin inputs.
- MONEY_W, 8, credit/price width, in units of 100 won.
- STOCK_W, 4, per-item stock width.
- COIN_VALUES, {8'd10,8'd5,8'd1}, packed N_COINS*MONEY_W values. Coin i uses bits [i*MONEY_W +: MONEY_W].
- INIT_PRICE, 5, reset price of every item.
- INIT_STOCK, 3, reset stock of every item.
- TIMEOUT_CYC, 1000000, idle cycles with credit>0 before auto-refund.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- coin_pulse  in  N_COINS  one-cycle coin-insert pulses
- item_sel  in  N_ITEMS  one-cycle item-button pulses
- refund_req  in  1  one-cycle refund pulse
- admin_mode  in  1  level; 1 = admin edit mode
- admin_price_up, admin_price_dn, admin_stock_up  in  1 each  one-cycle admin edit pulses
- dispense_valid  out  1  item ready to dispense
- dispense_item  out  $clog2(N_ITEMS)  index of the dispensed item
- dispense_ready  in  1  mechanism accepts the item
- change_valid  out  1  change amount valid
- change_amount  out  MONEY_W  change to return
- change_ready  in  1  coin returner accepts
- credit  out  MONEY_W  current credit, for the FND
- sel_idx  out  $clog2(N_ITEMS)  last selected/edited item
- sel_price  out  MONEY_W  price of sel_idx
- sel_stock  out  STOCK_W  stock of sel_idx
- event_code  out  3  0 NONE, 1 COIN, 2 VEND, 3 NO_MONEY, 4 SOLD_OUT, 5 REJECT, 6 CHANGE, 7 ADMIN
- event_pulse  out  1  one-cycle strobe qualifying event_code

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) produces:
  - state=IDLE, credit=0, sel_idx=0, all outputs 0, event_code=0.
  - Every price = INIT_PRICE, every stock = INIT_STOCK, idle counter = 0.
  - Reset mid-handshake aborts it and the held credit is lost.
- States: IDLE, DISPENSE, CHANGE, ADMIN.
- IDLE, admin_mode=1: go to ADMIN, event ADMIN.
- IDLE, admin_mode=0, processed in priority order each cycle:
  - Coin: coins are summed. If credit+sum > 2^MONEY_W-1, credit is unchanged and the event is REJECT. Otherwise credit += sum next cycle and the event is COIN.
  - item_sel: the lowest set bit wins and sel_idx is updated.
    - Stock of 0 gives SOLD_OUT.
    - price > credit gives NO_MONEY. This check uses pre-coin credit when a coin arrives in the same cycle, and that coin is still accepted.
    - Otherwise: credit -= price, stock -= 1, dispense_item = idx, dispense_valid = 1, go to DISPENSE, event VEND.
  - refund_req with credit>0: change_amount = credit, credit = 0, change_valid = 1, go to CHANGE. refund_req with credit=0 is ignored.
  - Timeout: the idle counter increments while credit>0 and no input pulses arrive. It clears on any pulse or when credit=0. At TIMEOUT_CYC-1 the block behaves as refund_req.
- Only one event_pulse is issued per cycle. Item/refund events take precedence over COIN/REJECT; the credit update from the coin still applies.
- DISPENSE:
  - dispense_valid stays high with dispense_item stable until a cycle where dispense_ready=1. It drops the following cycle and the state returns to IDLE.
  - Coins are accepted in this state. Item/refund/admin inputs are ignored.
- CHANGE:
  - change_valid and change_amount are held until change_ready=1, then the state goes to IDLE with event CHANGE.
  - Coins are rejected with event REJECT.
- ADMIN:
  - item_sel sets sel_idx.
  - admin_price_up: price += 1, saturating at max.
  - admin_price_dn: price -= 1, saturating at 1.
  - admin_stock_up: stock += 1, saturating at 2^STOCK_W-1.
  - Coins are rejected with event REJECT.
  - admin_mode=0 returns to IDLE. Credit is preserved across ADMIN.
- admin_mode changes during DISPENSE/CHANGE take effect only on return to IDLE.
- sel_price and sel_stock are combinational reads of the register file at sel_idx.

Decomposition:
- Package vending_pkg holds:
  - state enum (IDLE/DISPENSE/CHANGE/ADMIN)
  - event code constants EV_NONE..EV_ADMIN
  - helper function coin_sum(pulse, values)
- One sub-module, vending_item_store: price/stock register file with a read port, a decrement-stock port, and admin edit ports with saturation.

Test Plan:
- Reset, then coin0 (10) ×1, then item_sel[2] (price 5): credit 0→10→5, dispense_valid=1, dispense_item=2, stock[2]=2. With dispense_ready held 0 for 3 cycles the output is held; ready=1 gives valid=0 the next cycle.
- credit=3, item_sel[0]: event NO_MONEY, credit stays 3, stock unchanged. Then refund_req: change_amount=3, credit=0, change_valid held until change_ready.
- Buy item 4 three times with credit 20: stock 3→0. Fourth select gives SOLD_OUT and credit stays 5.
- credit=250, coin0 (10): REJECT, credit stays 250. Coin0 and coin1 in the same cycle from 0: credit=15, one COIN event.
- admin_mode=1, item_sel[7], price_dn ×6: price[7] 5→1 (saturates at 1). stock_up ×20: stock=15. admin_mode=0 returns to IDLE with credit preserved.
- TIMEOUT_CYC=16, credit=7, no inputs: change_valid rises on cycle 16 with change_amount=7. A coin at cycle 10 restarts the count.
